// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
// FSM encodings are fixed so waveforms match across tools.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_one_bit_adder.sv
// Single full-adder cell: the only arithmetic in the serial datapath.
// Pure combinational; carry is registered by the parent.
module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell.
// start/busy/done handshake; WIDTH+1 edges per operation.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, nxt;

  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             cy;
  logic             fs;
  logic             fc;
  logic             accept;
  logic             last;

  one_bit_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (cy),
    .sum   (fs),
    .c_out (fc)
  );

  assign accept  = start && (state != RUN);
  assign last    = (state == RUN) && (idx == LAST);
  assign res_nxt = {fs, res_sr[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = RUN;
      RUN:  if (idx == LAST) nxt = DONE;
      DONE: nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cy       <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // subtract is a + ~b + 1
      idx  <= '0;
      a_sr <= a;
      b_sr <= sub ? ~b : b;
      cy   <= sub ? 1'b1 : c_in;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      cy     <= fc;
      if (!last) begin
        idx <= idx + 1'b1;
      end
      // cy here is the carry into the MSB
      if (last) begin
        sum      <= res_nxt;
        c_out    <= fc;
        overflow <= cy ^ fc;
      end
    end
  end

endmodule
